// File: rtl/if_burst_monitor.sv
// rtl/if_burst_monitor.sv - groups CUT/golden output mismatches into bursts and queues burst records
module if_burst_monitor #(
    parameter int W       = 4,
    parameter int GAP_MAX = 4,
    parameter int DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [W-1:0]    cut_out,
    input  logic [W-1:0]    gold_out,
    input  logic            flush,
    input  logic            rec_ready,
    output logic            rec_valid,
    output logic [24+W-1:0] rec_data,
    output logic            in_burst,
    output logic [15:0]     err_count,
    output logic            overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 24 + W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [8:0]  GAP_LAST = 9'(GAP_MAX);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t        state;
    logic [15:0]   ts;
    logic [15:0]   start_ts;
    logic [7:0]    dur;
    logic [W-1:0]  mask;
    logic [7:0]    gap_cnt;

    logic [W-1:0]  diff;
    logic          mismatch;
    logic          clean;
    logic          gap_done;
    logic [9:0]    dur_gap;
    logic [7:0]    dur_gap_sat;
    logic [7:0]    dur_inc;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic [RW-1:0] rec_word;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;

    assign diff     = cut_out ^ gold_out;
    assign mismatch = en && (|diff);
    assign clean    = en && !(|diff);

    // gap_cnt counts clean samples already seen; this sample would be number gap_cnt+1
    assign gap_done = (GAP_MAX == 1) ? (state == BURST) :
                      ((state == GAP) && ((9'(gap_cnt) + 9'd1) == GAP_LAST));

    // a gap closed by a mismatch folds the gap samples plus this one into the duration
    assign dur_gap     = 10'(dur) + 10'(gap_cnt) + 10'd1;
    assign dur_gap_sat = (|dur_gap[9:8]) ? 8'hFF : dur_gap[7:0];
    assign dur_inc     = (dur == 8'hFF) ? 8'hFF : dur + 8'd1;

    assign push     = (flush && (state != IDLE)) || (clean && gap_done);
    assign rec_word = {start_ts, dur, mask};

    assign pop    = rec_valid && rec_ready;
    assign full   = (count == FULL_CNT);
    assign accept = push && (!full || pop);

    always_comb begin
        count_nxt = count;
        case ({accept, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    assign rec_data = rec_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_burst <= 1'b0;
            start_ts <= '0;
            dur      <= '0;
            mask     <= '0;
            gap_cnt  <= '0;
        end else if (flush && (state != IDLE)) begin
            state    <= IDLE;
            in_burst <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (mismatch) begin
                        state    <= BURST;
                        in_burst <= 1'b1;
                        start_ts <= ts;
                        dur      <= 8'd1;
                        mask     <= diff;
                    end
                end
                BURST: begin
                    if (mismatch) begin
                        dur  <= dur_inc;
                        mask <= mask | diff;
                    end else if (gap_done) begin
                        state    <= IDLE;
                        in_burst <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= 8'd1;
                    end
                end
                GAP: begin
                    if (mismatch) begin
                        state <= BURST;
                        dur   <= dur_gap_sat;
                        mask  <= mask | diff;
                    end else if (gap_done) begin
                        state    <= IDLE;
                        in_burst <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_burst <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            err_count <= '0;
        end else begin
            if (en) begin
                ts <= ts + 16'd1;
            end
            if (mismatch && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rec_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            count     <= count_nxt;
            rec_valid <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= rec_word;
        end
    end
endmodule

// File: tb/tb_if_burst_monitor.sv
// tb/tb_if_burst_monitor.sv - scoreboard bench for if_burst_monitor
module tb_if_burst_monitor;
    localparam int W  = 4;
    localparam int RW = 24 + W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [W-1:0]  cut_out = '0;
    logic [W-1:0]  gold_out = '0;
    logic          flush = 1'b0;
    logic          rec_ready = 1'b1;
    logic          rec_valid;
    logic [RW-1:0] rec_data;
    logic          in_burst;
    logic [15:0]   err_count;
    logic          overflow;

    logic [RW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_burst_monitor #(.W(W), .GAP_MAX(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .cut_out(cut_out), .gold_out(gold_out),
        .flush(flush), .rec_ready(rec_ready), .rec_valid(rec_valid),
        .rec_data(rec_data), .in_burst(in_burst), .err_count(err_count),
        .overflow(overflow)
    );

    function automatic logic [RW-1:0] mk(input logic [15:0] t, input logic [7:0] d,
                                         input logic [W-1:0] m);
        return {t, d, m};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake observed pops the next expected record
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_record: got 0x%0h expected none", rec_data);
            end else begin
                chk("record", 32'(rec_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic sample(input logic e, input logic [W-1:0] x);
        logic [W-1:0] g;
        g = W'($urandom);
        gold_out = g;
        cut_out  = g ^ x;
        en       = e;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic clean(input int n);
        repeat (n) sample(1'b1, '0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b1;
        flush    = 1'b1;
        gold_out = '0;
        cut_out  = '1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_rec_data", 32'(rec_data), 32'd0);
        chk("rst_in_burst", 32'(in_burst), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Single burst: mismatches at ts 3,4 (0001) and 6 (0100)
        exp_q.push_back(mk(16'd3, 8'd4, 4'b0101));
        clean(3);
        sample(1'b1, 4'b0001);
        chk("t1_in_burst", 32'(in_burst), 32'd1);
        sample(1'b1, 4'b0001);
        clean(1);
        sample(1'b1, 4'b0100);
        clean(3);
        chk("t1_not_yet", 32'(rec_valid), 32'd0);
        clean(1);
        chk("t1_rec_valid", 32'(rec_valid), 32'd1);
        chk("t1_err_count", 32'(err_count), 32'd3);
        wait_drain();

        // Gap split: mismatches at ts 0 and 5
        do_reset();
        exp_q.push_back(mk(16'd0, 8'd1, 4'b0010));
        exp_q.push_back(mk(16'd5, 8'd1, 4'b1000));
        sample(1'b1, 4'b0010);
        clean(4);
        sample(1'b1, 4'b1000);
        clean(4);
        wait_drain();

        // en gating inside GAP: burst ts 10..13 survives 10 idle cycles
        exp_q.push_back(mk(16'd10, 8'd4, 4'b0011));
        sample(1'b1, 4'b0001);
        clean(2);
        repeat (10) sample(1'b0, 4'b1111);
        chk("t3_in_burst", 32'(in_burst), 32'd1);
        chk("t3_no_rec", 32'(rec_valid), 32'd0);
        sample(1'b1, 4'b0010);
        clean(3);
        chk("t3_not_yet", 32'(rec_valid), 32'd0);
        clean(1);
        chk("t3_rec_valid", 32'(rec_valid), 32'd1);
        wait_drain();

        // Overflow: 9 bursts with consumer stalled, 10th push meets a pop
        do_reset();
        rec_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back(mk(16'(5 * k), 8'd1, 4'(k + 1)));
            sample(1'b1, 4'(k + 1));
            clean(4);
        end
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_rec_valid", 32'(rec_valid), 32'd1);
        chk("t4_head_stable", 32'(rec_data), 32'(mk(16'd0, 8'd1, 4'd1)));
        exp_q.push_back(mk(16'd45, 8'd1, 4'd10));
        sample(1'b1, 4'd10);
        clean(3);
        rec_ready = 1'b1;
        clean(1);
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);
        wait_drain();
        chk("t4_empty", 32'(rec_valid), 32'd0);

        // Flush in BURST at dur=2, then reset in GAP
        do_reset();
        chk("t5_overflow_cleared", 32'(overflow), 32'd0);
        exp_q.push_back(mk(16'd0, 8'd2, 4'b0011));
        sample(1'b1, 4'b0001);
        sample(1'b1, 4'b0010);
        do_flush();
        chk("t5_flush_in_burst", 32'(in_burst), 32'd0);
        chk("t5_flush_rec_valid", 32'(rec_valid), 32'd1);
        wait_drain();
        sample(1'b1, 4'b0100);
        clean(1);
        chk("t5_gap_in_burst", 32'(in_burst), 32'd1);
        do_reset();
        chk("t5_rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("t5_rst_rec_data", 32'(rec_data), 32'd0);
        chk("t5_rst_in_burst", 32'(in_burst), 32'd0);
        chk("t5_rst_err_count", 32'(err_count), 32'd0);
        chk("t5_rst_overflow", 32'(overflow), 32'd0);
        clean(6);
        chk("t5_no_rec", 32'(rec_valid), 32'd0);

        // Duration saturation and timestamp wrap
        do_reset();
        exp_q.push_back(mk(16'd0, 8'd255, 4'b0011));
        for (int i = 0; i < 300; i++) sample(1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010);
        chk("t6_in_burst", 32'(in_burst), 32'd1);
        clean(4);
        chk("t6_err_count", 32'(err_count), 32'd300);
        wait_drain();
        clean(65534 - 304);
        exp_q.push_back(mk(16'hFFFE, 8'd2, 4'b1100));
        sample(1'b1, 4'b0100);
        sample(1'b1, 4'b1000);
        clean(4);
        wait_drain();
        exp_q.push_back(mk(16'd4, 8'd1, 4'b0001));
        sample(1'b1, 4'b0001);
        clean(4);
        wait_drain();
        chk("t6_err_final", 32'(err_count), 32'd303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/if_burst_monitor.md
IF_BURST_MONITOR -- requirements
Module: if_burst_monitor

Interface
REQ-001 SHALL have parameter W, default 4, the width of the observed circuit-output vector.
REQ-002 SHALL have parameter GAP_MAX, default 4, the number of consecutive clean samples that closes a burst (legal 1..255).
REQ-003 SHALL have parameter DEPTH, default 8, the record FIFO depth (power of two, >=2).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, the sole clock, rising-edge.
REQ-006 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 SHALL have port en, input, 1, the sample strobe; cut_out and gold_out are valid when high.
REQ-008 SHALL have port cut_out, input, W, the outputs of the circuit under test.
REQ-009 SHALL have port gold_out, input, W, the fault-free reference outputs.
REQ-010 SHALL have port flush, input, 1, which force-closes an open burst.
REQ-011 SHALL have port rec_ready, input, 1, the consumer ready signal.
REQ-012 SHALL have port rec_valid, output, 1, high when a record is available at the FIFO head.
REQ-013 SHALL have port rec_data, output, 24+W, carrying {start_ts[15:0], dur[7:0], mask[W-1:0]} with start_ts in the MSBs.
REQ-014 SHALL have port in_burst, output, 1, high in states BURST or GAP.
REQ-015 SHALL have port err_count, output, 16, the total number of mismatching samples.
REQ-016 SHALL have port overflow, output, 1, a sticky record-drop flag.

Function
REQ-017 SHALL define a mismatch as en=1 and (cut_out XOR gold_out) != 0; a clean sample is en=1 with XOR == 0.
REQ-018 SHALL keep a 16-bit timestamp ts that increments on every en=1 cycle and wraps from 0xFFFF to 0x0000.
REQ-019 SHALL hold all state, ts and counters unchanged when en=0, except for flush and FIFO pops.
REQ-020 SHALL implement FSM states IDLE, BURST and GAP.
REQ-021 SHALL, in IDLE on a mismatch, go to BURST and load start_ts=ts (pre-increment value), dur=1, mask=XOR.
REQ-022 SHALL, in BURST on a mismatch, do dur+=1 and mask|=XOR.
REQ-023 SHALL, in BURST on a clean sample, go to GAP with gap_cnt=1.
REQ-024 SHALL, in GAP on a mismatch, go to BURST with dur+=gap_cnt+1 and mask|=XOR.
REQ-025 SHALL, in GAP on a clean sample, do gap_cnt+=1.
REQ-026 SHALL, in GAP when gap_cnt reaches GAP_MAX, push the record and return to IDLE; with GAP_MAX=1 the record is pushed on the first clean sample.
REQ-027 SHALL make dur equal to the sample count from the first to the last mismatch inclusive, saturating at 255.
REQ-028 SHALL, when flush=1 in BURST or GAP, push the record and go to IDLE that cycle, ignoring any sample in that cycle for the burst; flush in IDLE has no effect.
REQ-029 SHALL make a pushed record visible on rec_valid/rec_data the cycle after the push.
REQ-030 SHALL pop the FIFO on rec_valid & rec_ready; rec_data SHALL be stable while rec_valid=1 and rec_ready=0.
REQ-031 SHALL, on a push with FIFO full and no same-cycle pop, drop the record and set overflow=1 until reset; a push with full and a same-cycle pop SHALL be accepted.
REQ-032 SHALL increment err_count on every mismatch, saturating at 0xFFFF.
REQ-033 SHALL keep in_burst as a registered decode of the state (BURST or GAP).

Reset
REQ-034 SHALL, on rst=1 at a rising edge, set state=IDLE, ts=0, err_count=0, overflow=0, in_burst=0, rec_valid=0, rec_data=0, empty the FIFO, and discard any open burst.
REQ-035 SHALL give rst priority over en, flush and rec_ready in the same cycle.

Verification
REQ-036 SHALL cover a single burst: after reset with GAP_MAX=4, mismatches XOR=0001 at ts 3,4 and XOR=0100 at ts 6, then clean samples -> one record {start_ts=3, dur=4, mask=0101} with rec_valid high the cycle after the 4th clean sample (ts 10), and err_count=3.
REQ-037 SHALL cover a gap split: mismatches at ts 0 and 5 with GAP_MAX=4 -> two records {0,1,...} and {5,1,...}.
REQ-038 SHALL cover en gating: with en=0 for 10 cycles inside GAP -> no record, ts frozen, and the burst continues on the next sample.
REQ-039 SHALL cover overflow: 9 bursts with rec_ready=0 and DEPTH=8 -> 8 records retained and overflow=1; a 10th push with a same-cycle pop -> accepted.
REQ-040 SHALL cover flush and reset: flush in BURST at dur=2 -> record pushed with dur=2 and in_burst=0 the next cycle; rst asserted in GAP -> no record and all outputs at reset values.
REQ-041 SHALL cover saturation and wrap: 300 consecutive mismatches -> dur=255 and err_count=300; starting ts at 0xFFFE -> ts wraps to 0 and start_ts is recorded as 0xFFFE.
